// File: rtl/airlock_pkg.sv
// Shared definitions for the airlock timing blocks.
//   - state encoding for the timer sequencer FSM
//   - counter width, request id width, number of request sources
//   - default phase durations in seconds (5/7/8 minutes)
//   - lowest_set(): index of the lowest set bit of a request vector
package airlock_pkg;

   localparam int SEC_W   = 10;
   localparam int ID_W    = 2;
   localparam int NUM_REQ = 3;

   localparam int SECS0_DEF = 300;
   localparam int SECS1_DEF = 420;
   localparam int SECS2_DEF = 480;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_LOAD = 2'd1;
   localparam state_t ST_RUN  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   // Scans from the top down so the lowest set index is the one left standing.
   function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
      logic [ID_W-1:0] id;
      id = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (v[i]) id = ID_W'(i);
      end
      return id;
   endfunction

endpackage

// File: rtl/timer_sequencer_req_queue.sv
// req_queue: pending-request register plus fixed-priority grant.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   req[2:0]        one-cycle request pulses
//   grantEn         sequencer is able to accept a grant this cycle
//   pending[2:0]    queued, not-yet-granted requests
//   grantId         lowest pending index (valid when grantValid)
//   grantValid      at least one request pending
module req_queue
   import airlock_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               grantEn,
   output logic [NUM_REQ-1:0] pending,
   output logic [ID_W-1:0]    grantId,
   output logic               grantValid
);

   logic [NUM_REQ-1:0] clr;

   always_comb begin
      grantValid = |pending;
      grantId    = lowest_set(pending);
      clr        = '0;
      if (grantEn && grantValid) clr[grantId] = 1'b1;
   end

   // OR-ing req after the clear lets a request arriving on its own grant
   // cycle stay queued for a second run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pending <= '0;
      else       pending <= (pending & ~clr) | req;
   end

endmodule

// File: rtl/timer_sequencer.sv
// timer_sequencer: queues timing requests from three sources and drives the
// countdown counter (start/counterSeconds), reporting done or aborted with
// the id of the finished request.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   req[2:0]         request pulses (bit 0 highest priority)
//   abort            cancels the running request (RUN only)
//   signal           counter at zero
//   start            one-cycle load strobe to the counter
//   counterSeconds   duration presented to the counter
//   busy             high in LOAD and RUN
//   activeId         id of the request being timed
//   done / aborted   one-cycle completion / abort-acknowledge pulses
//   doneId           id for the last done/aborted pulse
//   pending[2:0]     queued requests
//
// state   | meaning
// IDLE    | waiting; grants the lowest pending request
// LOAD    | start strobe, counter loads at the end of this cycle
// RUN     | counter running; watch abort and signal
// DONE    | done pulse for activeId
module timer_sequencer
   import airlock_pkg::*;
#(
   parameter int SECS0 = SECS0_DEF,
   parameter int SECS1 = SECS1_DEF,
   parameter int SECS2 = SECS2_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               abort,
   input  logic               signal,
   output logic               start,
   output logic [SEC_W-1:0]   counterSeconds,
   output logic               busy,
   output logic [ID_W-1:0]    activeId,
   output logic               done,
   output logic               aborted,
   output logic [ID_W-1:0]    doneId,
   output logic [NUM_REQ-1:0] pending
);

   localparam int SEC_MAX = (1 << SEC_W) - 1;

   if (SECS0 < 0 || SECS0 > SEC_MAX || SECS1 < 0 || SECS1 > SEC_MAX ||
       SECS2 < 0 || SECS2 > SEC_MAX) begin : g_secs_range
      $error("timer_sequencer: SECSn must be within 0..1023");
   end

   state_t             state_q;
   logic               grant_en;
   logic [ID_W-1:0]    grant_id;
   logic               grant_valid;
   logic [SEC_W-1:0]   secs_sel;

   assign grant_en = (state_q == ST_IDLE);

   req_queue u_req_queue (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .grantEn    (grant_en),
      .pending    (pending),
      .grantId    (grant_id),
      .grantValid (grant_valid)
   );

   always_comb begin
      secs_sel = SEC_W'(SECS0);
      case (grant_id)
         2'd1:    secs_sel = SEC_W'(SECS1);
         2'd2:    secs_sel = SEC_W'(SECS2);
         default: secs_sel = SEC_W'(SECS0);
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         counterSeconds <= '0;
         activeId       <= '0;
         doneId         <= '0;
         aborted        <= 1'b0;
      end else begin
         aborted <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_valid) begin
                  activeId       <= grant_id;
                  counterSeconds <= secs_sel;
                  state_q        <= ST_LOAD;
               end
            end
            ST_LOAD: state_q <= ST_RUN;
            ST_RUN: begin
               // abort has priority over a simultaneous signal
               if (abort) begin
                  aborted <= 1'b1;
                  doneId  <= activeId;
                  state_q <= ST_IDLE;
               end else if (signal) begin
                  doneId  <= activeId;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign start = (state_q == ST_LOAD);
   assign busy  = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_timer_sequencer.sv
module tb_timer_sequencer;
   import airlock_pkg::*;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [2:0]       req = '0;
   logic             abort = 1'b0;
   logic             signal;
   logic             start;
   logic [9:0]       counterSeconds;
   logic             busy;
   logic [1:0]       activeId;
   logic             done;
   logic             aborted;
   logic [1:0]       doneId;
   logic [2:0]       pending;

   timer_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .req            (req),
      .abort          (abort),
      .signal         (signal),
      .start          (start),
      .counterSeconds (counterSeconds),
      .busy           (busy),
      .activeId       (activeId),
      .done           (done),
      .aborted        (aborted),
      .doneId         (doneId),
      .pending        (pending)
   );

   always #5 clk = ~clk;

   // countdown counter model, one count per clock
   logic [9:0] cnt = '0;
   always @(posedge clk) begin
      if (start)         cnt <= counterSeconds;
      else if (cnt != 0) cnt <= cnt - 10'd1;
   end
   assign signal = (cnt == 0);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;   // 0 start, 1 done, 2 aborted
      int id;
      int secs;
      int cyc;    // -1 = any cycle
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   string kname[3] = '{"start", "done", "aborted"};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int id, input int secs, input int c);
      exp_t e;
      e.kind = kind; e.id = id; e.secs = secs; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic mon(input int kind, input int id, input int secs);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_%s: got id %0d expected no event (cycle %0d)", kname[kind], id, cyc);
      end else begin
         e = sb.pop_front();
         chk({kname[kind], "_kind"}, kind, e.kind);
         chk({kname[kind], "_id"}, id, e.id);
         if (kind == 0) chk("start_secs", secs, e.secs);
         if (e.cyc >= 0) chk({kname[kind], "_cycle"}, cyc, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (start) begin
            mon(0, int'(activeId), int'(counterSeconds));
            chk("busy_in_load", int'(busy), 1);
         end
         if (done)    mon(1, int'(doneId), 0);
         if (aborted) mon(2, int'(doneId), 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_req(input logic [2:0] v);
      req = v;
      tick();
      req = '0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy || pending != 0) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain_timeout: got %0d outstanding expected 0 (cycle %0d)", sb.size(), cyc);
         sb.delete();
      end
      repeat (3) tick();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_start"}, int'(start), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_aborted"}, int'(aborted), 0);
      chk({tag, "_activeId"}, int'(activeId), 0);
      chk({tag, "_doneId"}, int'(doneId), 0);
      chk({tag, "_secs"}, int'(counterSeconds), 0);
      chk({tag, "_pending"}, int'(pending), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, s0, d0, s1, d1, s2, d2, n;
      bit found;

      repeat (3) tick();
      chk_reset_vals("reset");
      reset = 1'b0;
      tick();

      // abort while idle is ignored
      abort = 1'b1;
      tick();
      abort = 1'b0;
      repeat (2) tick();

      // single request 1
      k = cyc;
      push(0, 1, 420, k + 2);
      push(1, 1, 0, k + 2 + 422);
      pulse_req(3'b010);
      chk("single_pending", int'(pending), 2);
      wait_idle(1000);

      // simultaneous requests, serviced 0,1,2 with one idle cycle between
      k  = cyc;
      s0 = k + 2;   d0 = s0 + 302;
      s1 = d0 + 2;  d1 = s1 + 422;
      s2 = d1 + 2;  d2 = s2 + 482;
      push(0, 0, 300, s0); push(1, 0, 0, d0);
      push(0, 1, 420, s1); push(1, 1, 0, d1);
      push(0, 2, 480, s2); push(1, 2, 0, d2);
      pulse_req(3'b111);
      chk("simul_pending", int'(pending), 7);
      wait_idle(3000);

      // abort mid-RUN on request 2
      k = cyc;
      push(0, 2, 480, k + 2);
      pulse_req(3'b100);
      repeat (48) tick();
      push(2, 2, 0, cyc + 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_idle(100);
      chk("abort_doneId", int'(doneId), 2);

      // request 0 after abort; abort during LOAD is ignored
      k = cyc;
      push(0, 0, 300, k + 2);
      push(1, 0, 0, k + 304);
      pulse_req(3'b001);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_idle(1000);

      // abort and signal together in RUN: aborted only
      k = cyc;
      push(0, 1, 420, k + 2);
      pulse_req(3'b010);
      found = 0;
      for (n = 0; n < 1000; n++) begin
         if (signal && busy && !start) begin
            found = 1;
            break;
         end
         tick();
      end
      chk("collision_found", int'(found), 1);
      chk("collision_cycle", cyc, k + 3 + 420);
      push(2, 1, 0, cyc + 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_idle(100);

      // set/clear race: req[1] on its own grant cycle runs twice
      k = cyc;
      push(0, 1, 420, k + 2);   push(1, 1, 0, k + 424);
      push(0, 1, 420, k + 426); push(1, 1, 0, k + 848);
      req = 3'b010;
      tick();
      req = 3'b010;
      tick();
      req = '0;
      chk("race_pending", int'(pending), 2);
      wait_idle(2000);

      // reset mid-RUN with request 2 queued
      k = cyc;
      push(0, 0, 300, k + 2);
      pulse_req(3'b001);
      repeat (9) tick();
      pulse_req(3'b100);
      chk("pre_reset_pending", int'(pending), 4);
      chk("pre_reset_busy", int'(busy), 1);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("midreset");
      sb.delete();
      tick();
      reset = 1'b0;
      repeat (400) tick();
      chk("post_reset_pending", int'(pending), 0);
      chk("post_reset_busy", int'(busy), 0);

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
